mio_bus_arbiter: RTL and testbench
==================================

MIO_BUS_ARBITER -- requirements
Module: mio_bus_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_WAIT, default 1: extra access cycles for region addr[31:28]==4'h0 (synchronous data RAM).
REQ-002 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have ports m0_req, m1_req, input, 1 each: transfer request, level, held until matching ack.
REQ-005 The block SHALL have ports m0_we, m1_we, input, 1 each: 1 = write, 0 = read.
REQ-006 The block SHALL have ports m0_addr, m1_addr, input, 32 each: byte address.
REQ-007 The block SHALL have ports m0_wdata, m1_wdata, input, 32 each: write data.
REQ-008 The block SHALL have ports m0_ack, m1_ack, output, 1 each: one-cycle completion pulse.
REQ-009 The block SHALL have port rdata, output, 32: read data, shared by both masters, valid in the ack cycle.
REQ-010 The block SHALL have port bus_addr, output, 32: to the MIO bus addr_bus.
REQ-011 The block SHALL have port bus_wdata, output, 32: to Cpu_data2bus.
REQ-012 The block SHALL have port bus_mem_w, output, 1: to mem_w.
REQ-013 The block SHALL have port bus_rdata, input, 32: from Cpu_data4bus.
REQ-014 The block SHALL have port grant, output, 2: one-hot owner, bit0 = m0, bit1 = m1.
REQ-015 The block SHALL have port busy, output, 1: high when state != IDLE.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, ACCESS and RESP.
REQ-017 In IDLE with any req high, the block SHALL select a winner, latch that master's addr, we and wdata, load the wait counter (RAM_WAIT if addr[31:28]==0, else 0) and enter ACCESS.
REQ-018 On simultaneous requests, the winner SHALL be the master not granted last (round-robin); last_grant resets to m1, so m0 wins the first tie.
REQ-019 A single requester SHALL win regardless of last_grant.
REQ-020 In ACCESS, bus_addr and bus_wdata SHALL be driven from the latched values, and the counter SHALL decrement each cycle while nonzero.
REQ-021 bus_mem_w SHALL equal the latched we only in the ACCESS cycle where the counter is 0 (exactly one write strobe per transfer), and SHALL be 0 otherwise.
REQ-022 In the ACCESS cycle with counter 0, the block SHALL register bus_rdata into rdata and enter RESP.
REQ-023 In RESP, the block SHALL pulse the winner's ack for one cycle, update last_grant, and return to IDLE.
REQ-024 Latency, req-high cycle to ack cycle, SHALL be 2 cycles for peripherals and 2+RAM_WAIT cycles for region 0.
REQ-025 grant SHALL be one-hot during ACCESS and RESP, and 2'b00 in IDLE.
REQ-026 bus_addr and bus_wdata SHALL hold their last latched values outside ACCESS.
REQ-027 A req still high in the IDLE cycle after RESP SHALL be arbitrated as a new request.
REQ-028 Deasserting req mid-transfer SHALL NOT abort the transfer; the ack is still issued.
REQ-029 Changes to a master's addr, we or wdata after latching SHALL have no effect on the current transfer.
REQ-030 For write transfers, rdata SHALL still be updated from bus_rdata; its value is don't-care to masters.

Reset
REQ-031 While rst_n==0 at a clk edge, the block SHALL enter IDLE and reset all of the following: grant=0, busy=0, m0_ack=0, m1_ack=0, bus_mem_w=0, bus_addr=0, bus_wdata=0, rdata=0, wait counter=0, last_grant=m1.
REQ-032 A reset during ACCESS or RESP SHALL abort the transfer with no ack and no further bus_mem_w strobe.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the RAM region code 4'h0.
REQ-034 The round-robin selection SHALL be one sub-module, mio_rr_pick: inputs 2 requests and last_grant, output one-hot winner, purely combinational.

Verification
REQ-035 Reset then m0 writes 0xE0000000 with data 0x12345678 -> bus_mem_w high exactly 1 cycle with that address and data; m0_ack 2 cycles after req.
REQ-036 m1 reads 0x00000010 with RAM_WAIT=1 and bus_rdata=0xCAFEF00D -> m1_ack 3 cycles after req, rdata=0xCAFEF00D, bus_mem_w never high.
REQ-037 m0 and m1 request together and hold req -> grants alternate m0, m1, m0, m1; no master starves.
REQ-038 rst_n low during the ACCESS of a RAM write -> no ack, bus_mem_w stays 0, grant=0 on the next cycle.
REQ-039 m0 drops req and changes addr to 0xF0000004 mid-ACCESS of a 0xE0000000 transfer -> transfer completes to 0xE0000000 and m0_ack still pulses.

Source files
------------

// File: rtl/mio_bus_arbiter_pkg.sv
// Shared definitions for the two-master MIO bus arbiter: the FSM encoding,
// the RAM region code and the one-hot grant values.
package mio_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [3:0] RAM_REGION = 4'h0;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    function automatic logic is_ram_region(input logic [31:0] addr);
        return addr[31:28] == RAM_REGION;
    endfunction

endpackage

// File: rtl/mio_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, and on a tie the
// master that was not granted last wins. Purely combinational.
module mio_rr_pick
    import mio_bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] winner_o
);

    always_comb begin
        winner_o = GRANT_NONE;
        case (req_i)
            2'b01:   winner_o = GRANT_M0;
            2'b10:   winner_o = GRANT_M1;
            2'b11:   winner_o = (last_grant_i == GRANT_M0) ? GRANT_M1 : GRANT_M0;
            default: winner_o = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Arbitrates two masters onto the single MIO bus; the winner's request is
// latched, driven for 1+wait cycles, and completed with a one-cycle ack.
module mio_bus_arbiter
    import mio_bus_arbiter_pkg::*;
#(
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_mem_w,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam int unsigned CNT_W = (RAM_WAIT < 1) ? 1 : $clog2(RAM_WAIT + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   wait_q;
    logic [1:0]         last_grant_q;
    logic [1:0]         grant_q;
    logic               we_q;
    logic               m0_ack_q;
    logic               m1_ack_q;
    logic               bus_mem_w_q;
    logic [31:0]        bus_addr_q;
    logic [31:0]        bus_wdata_q;
    logic [31:0]        rdata_q;

    logic [1:0]         winner_d;
    logic [31:0]        sel_addr_d;
    logic [31:0]        sel_wdata_d;
    logic               sel_we_d;
    logic [CNT_W-1:0]   wait_load_d;

    mio_rr_pick u_pick (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_grant_q),
        .winner_o     (winner_d)
    );

    always_comb begin
        sel_addr_d  = winner_d[1] ? m1_addr  : m0_addr;
        sel_wdata_d = winner_d[1] ? m1_wdata : m0_wdata;
        sel_we_d    = winner_d[1] ? m1_we    : m0_we;
        wait_load_d = is_ram_region(sel_addr_d) ? CNT_W'(RAM_WAIT) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            last_grant_q <= GRANT_M1;
            grant_q      <= GRANT_NONE;
            we_q         <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            bus_mem_w_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            bus_mem_w_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (winner_d != GRANT_NONE) begin
                        grant_q     <= winner_d;
                        bus_addr_q  <= sel_addr_d;
                        bus_wdata_q <= sel_wdata_d;
                        we_q        <= sel_we_d;
                        wait_q      <= wait_load_d;
                        // The strobe is registered, so it is raised one cycle
                        // ahead: here when there is no wait, else at count 1.
                        bus_mem_w_q <= sel_we_d && (wait_load_d == '0);
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (wait_q != '0) begin
                        wait_q      <= wait_q - CNT_W'(1);
                        bus_mem_w_q <= we_q && (wait_q == CNT_W'(1));
                    end else begin
                        rdata_q  <= bus_rdata;
                        m0_ack_q <= grant_q[0];
                        m1_ack_q <= grant_q[1];
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    last_grant_q <= grant_q;
                    grant_q      <= GRANT_NONE;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign rdata     = rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_mem_w = bus_mem_w_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: a table of single transfers followed by
// hand-written round-robin, reset-abort and mid-transfer-change sequences.
module tb_mio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
    logic        bus_mem_w, busy;
    logic [1:0]  grant;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.RAM_WAIT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m1_req    (m1_req),
        .m0_we     (m0_we),
        .m1_we     (m1_we),
        .m0_addr   (m0_addr),
        .m1_addr   (m1_addr),
        .m0_wdata  (m0_wdata),
        .m1_wdata  (m1_wdata),
        .m0_ack    (m0_ack),
        .m1_ack    (m1_ack),
        .rdata     (rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_mem_w (bus_mem_w),
        .bus_rdata (bus_rdata),
        .grant     (grant),
        .busy      (busy)
    );

    typedef struct {
        logic        mst;     // 0 = m0, 1 = m1
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;     // bus_rdata presented during the transfer
        int          lat;     // expected req-to-ack cycles
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          strobes;
        logic        wrong_ack;
        logic [31:0] s_addr, s_data, rd_at_ack;
        logic [1:0]  g_at_ack;
        logic [1:0]  g_exp;
        lat = 0; strobes = 0; wrong_ack = 1'b0;
        s_addr = '0; s_data = '0; rd_at_ack = '0; g_at_ack = '0;
        g_exp = v.mst ? 2'b10 : 2'b01;
        bus_rdata = v.brd;
        if (!v.mst) begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end else begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (bus_mem_w) begin
                strobes++;
                s_addr = bus_addr;
                s_data = bus_wdata;
            end
            if (v.mst ? m0_ack : m1_ack) wrong_ack = 1'b1;
            if (v.mst ? m1_ack : m0_ack) begin
                lat       = c;
                rd_at_ack = rdata;
                g_at_ack  = grant;
                m0_req    = 1'b0;
                m1_req    = 1'b0;
            end
        end
        check($sformatf("v%0d latency", idx), lat, v.lat);
        check($sformatf("v%0d strobes", idx), strobes, v.we ? 1 : 0);
        if (v.we) begin
            check($sformatf("v%0d strobe_addr", idx), s_addr, v.addr);
            check($sformatf("v%0d strobe_data", idx), s_data, v.wdata);
        end
        check($sformatf("v%0d rdata", idx), rd_at_ack, v.brd);
        check($sformatf("v%0d grant", idx), {30'd0, g_at_ack}, {30'd0, g_exp});
        check($sformatf("v%0d wrong_ack", idx), {31'd0, wrong_ack}, 32'd0);
        tick();
        check($sformatf("v%0d idle_busy", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d idle_grant", idx), {30'd0, grant}, 32'd0);
        check($sformatf("v%0d hold_addr", idx), bus_addr, v.addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   order[4];
        int   nack;
        int   bad_grant;
        int   strobes;
        int   acks;
        logic both;

        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        bus_rdata = '0;

        vecs[0] = '{1'b0, 1'b1, 32'hE000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 2};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hCAFE_F00D, 3};
        vecs[2] = '{1'b0, 1'b0, 32'h8000_0020, 32'h0000_0000, 32'h0BAD_F00D, 2};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'h1111_1111, 3};
        vecs[4] = '{1'b1, 1'b1, 32'hF000_0004, 32'h5A5A_0001, 32'h2222_2222, 2};
        vecs[5] = '{1'b0, 1'b0, 32'h0FFF_FFFC, 32'h0000_0000, 32'h3333_4444, 3};
        vecs[6] = '{1'b0, 1'b0, 32'h1000_0000, 32'h0000_0000, 32'h5555_6666, 2};

        // Reset state
        repeat (2) tick();
        check("rst busy",      {31'd0, busy},      32'd0);
        check("rst grant",     {30'd0, grant},     32'd0);
        check("rst acks",      {30'd0, m1_ack, m0_ack}, 32'd0);
        check("rst mem_w",     {31'd0, bus_mem_w}, 32'd0);
        check("rst bus_addr",  bus_addr,  32'd0);
        check("rst bus_wdata", bus_wdata, 32'd0);
        check("rst rdata",     rdata,     32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Simultaneous held requests alternate starting with m0 after reset
        do_reset();
        m0_we = 1'b0; m0_addr = 32'h8000_0000;
        m1_we = 1'b0; m1_addr = 32'h9000_0000;
        bus_rdata = 32'h1357_2468;
        m0_req = 1'b1; m1_req = 1'b1;
        nack = 0; bad_grant = 0; both = 1'b0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            tick();
            if (m0_ack && m1_ack) both = 1'b1;
            if (busy && grant != 2'b01 && grant != 2'b10) bad_grant++;
            if (!busy && grant != 2'b00) bad_grant++;
            if (m0_ack) begin
                order[nack] = 0; nack++;
            end else if (m1_ack) begin
                order[nack] = 1; nack++;
            end
            if (nack == 4) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
        end
        check("rr ack_count", nack, 4);
        for (int i = 0; i < 4; i++)
            if (i < nack) check($sformatf("rr order%0d", i), order[i], i % 2);
        check("rr both_ack", {31'd0, both}, 32'd0);
        check("rr grant_onehot", bad_grant, 0);
        tick();
        check("rr idle_after", {31'd0, busy}, 32'd0);

        // Reset during the ACCESS of a RAM write aborts it
        m0_we = 1'b1; m0_addr = 32'h0000_0040; m0_wdata = 32'h7777_8888;
        m0_req = 1'b1;
        tick();
        check("abort in_access", {31'd0, busy}, 32'd1);
        check("abort grant_m0", {30'd0, grant}, 32'd1);
        strobes = bus_mem_w ? 1 : 0;
        acks = 0;
        rst_n = 1'b0;
        m0_req = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (bus_mem_w) strobes++;
            if (m0_ack || m1_ack) acks++;
            if (c == 2) begin
                check("abort grant", {30'd0, grant}, 32'd0);
                check("abort busy", {31'd0, busy}, 32'd0);
                check("abort bus_addr", bus_addr, 32'd0);
                rst_n = 1'b1;
            end
        end
        check("abort strobes", strobes, 0);
        check("abort acks", acks, 0);

        // Input changes after latching do not disturb the transfer
        m0_we = 1'b1; m0_addr = 32'hE000_0000; m0_wdata = 32'h1111_2222;
        m0_req = 1'b1;
        tick();
        m0_req = 1'b0; m0_we = 1'b0;
        m0_addr = 32'hF000_0004; m0_wdata = 32'hFFFF_FFFF;
        check("chg strobe", {31'd0, bus_mem_w}, 32'd1);
        check("chg addr", bus_addr, 32'hE000_0000);
        check("chg wdata", bus_wdata, 32'h1111_2222);
        strobes = 0; acks = 0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (bus_mem_w) strobes++;
            if (m0_ack) acks++;
        end
        check("chg ack", acks, 1);
        check("chg extra_strobes", strobes, 0);
        check("chg hold_addr", bus_addr, 32'hE000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
